// File: rtl/vscale_hasti_arbiter.sv
// -----------------------------------------------------------------------------
// vscale_hasti_arbiter
//
// Two-master, one-slave HASTI (AHB-Lite) arbiter. Master 0 is the core's
// instruction port and master 1 its data port. Both share one SRAM slave.
// Arbitration is round-robin. An uncontended transfer passes straight through
// with no added latency. A master that loses arbitration while its previous
// data phase completes gets that response latched here and delivered later.
//
// Ports (per-master buses are packed {m1, m0}):
//   clk, reset              clock; asynchronous active-high reset
//   m_haddr/hwrite/hsize/   master address-phase inputs
//   m_htrans, m_hwdata      master transfer type and data-phase write data
//   m_hrdata/hready/hresp   per-master data-phase responses
//   s_haddr/hwrite/hsize/   slave address phase, from the granted master
//   s_htrans, s_hwdata      slave transfer type; write data from the data-phase owner
//   s_hrdata/hready/hresp   slave responses
// -----------------------------------------------------------------------------
module vscale_hasti_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] m_haddr,
    input  logic [1:0]  m_hwrite,
    input  logic [5:0]  m_hsize,
    input  logic [3:0]  m_htrans,
    input  logic [63:0] m_hwdata,
    output logic [63:0] m_hrdata,
    output logic [1:0]  m_hready,
    output logic [1:0]  m_hresp,
    output logic [31:0] s_haddr,
    output logic        s_hwrite,
    output logic [2:0]  s_hsize,
    output logic [1:0]  s_htrans,
    output logic [31:0] s_hwdata,
    input  logic [31:0] s_hrdata,
    input  logic        s_hready,
    input  logic        s_hresp
);

    logic        last_grant;   // master accepted most recently
    logic [1:0]  dp_own;       // one-hot owner of the slave data phase, or 0
    logic [1:0]  done;         // completed data phase not yet delivered
    logic [31:0] rdata_q [2];
    logic [1:0]  resp_q;

    logic [1:0]  req;
    logic [1:0]  grant;
    logic [1:0]  accept;
    logic [1:0]  data_ok;
    logic [1:0]  addr_ok;
    logic [1:0]  latch;

    // HTRANS bit 1 distinguishes NONSEQ/SEQ from IDLE/BUSY.
    assign req = {m_htrans[3], m_htrans[1]};

    // Grant depends only on req and last_grant. It never depends on s_hready.
    // This keeps the slave address phase free of any path from s_hready.
    // NOTE: every signal driven in always_comb gets a default first. Any path
    // that leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign accept = grant & {2{s_hready}};

    // Slave address phase. With no grant, master 0's fields are shown and the
    // transfer is forced to IDLE.
    always_comb begin
        s_haddr  = m_haddr[31:0];
        s_hwrite = m_hwrite[0];
        s_hsize  = m_hsize[2:0];
        s_htrans = 2'b00;
        if (grant[1]) begin
            s_haddr  = m_haddr[63:32];
            s_hwrite = m_hwrite[1];
            s_hsize  = m_hsize[5:3];
            s_htrans = m_htrans[3:2];
        end else if (grant[0]) begin
            s_htrans = m_htrans[1:0];
        end
    end

    assign s_hwdata = dp_own[1] ? m_hwdata[63:32] : m_hwdata[31:0];

    // A master is ready when its data phase has completed (now or earlier)
    // and its pending address phase, if any, is taken this cycle.
    assign data_ok  = done | ~dp_own | {2{s_hready}};
    assign addr_ok  = ~req | accept;
    assign m_hready = reset ? 2'b11 : (data_ok & addr_ok);

    // The slave finished this master's data phase, but the master is stalled
    // by its own address phase. Capture the response so it is not lost.
    assign latch = dp_own & {2{s_hready}} & ~m_hready;

    always_comb begin
        m_hrdata = '0;
        m_hresp  = '0;
        for (int i = 0; i < 2; i++) begin
            if (done[i]) begin
                m_hrdata[32*i +: 32] = rdata_q[i];
                m_hresp[i]           = resp_q[i];
            end else if (dp_own[i]) begin
                m_hrdata[32*i +: 32] = s_hrdata;
                m_hresp[i]           = s_hresp;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            dp_own     <= 2'b00;
        end else begin
            if (accept[0]) begin
                last_grant <= 1'b0;
            end else if (accept[1]) begin
                last_grant <= 1'b1;
            end
            if (s_hready) begin
                dp_own <= accept;
            end
        end
    end

    // NOTE: the response holding registers are reset, not just the flags that
    // qualify them. This keeps m_hrdata/m_hresp defined from the first cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done       <= 2'b00;
            resp_q     <= 2'b00;
            rdata_q[0] <= '0;
            rdata_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_hready[i]) begin
                    done[i] <= 1'b0;
                end else if (latch[i]) begin
                    done[i]    <= 1'b1;
                    rdata_q[i] <= s_hrdata;
                    resp_q[i]  <= s_hresp;
                end
            end
        end
    end

endmodule

// File: tb/tb_vscale_hasti_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vscale_hasti_arbiter
//
// Directed bench for vscale_hasti_arbiter. It has a small single-cycle SRAM
// slave model. The bench controls wait states and errors through stall and
// err_force. Inputs change 1 time unit after a rising edge. Outputs are
// checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_vscale_hasti_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] m_haddr;
    logic [1:0]  m_hwrite;
    logic [5:0]  m_hsize;
    logic [3:0]  m_htrans;
    logic [63:0] m_hwdata;
    logic [63:0] m_hrdata;
    logic [1:0]  m_hready;
    logic [1:0]  m_hresp;
    logic [31:0] s_haddr;
    logic        s_hwrite;
    logic [2:0]  s_hsize;
    logic [1:0]  s_htrans;
    logic [31:0] s_hwdata;
    logic [31:0] s_hrdata;
    logic        s_hready;
    logic        s_hresp;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vscale_hasti_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m_haddr  (m_haddr),
        .m_hwrite (m_hwrite),
        .m_hsize  (m_hsize),
        .m_htrans (m_htrans),
        .m_hwdata (m_hwdata),
        .m_hrdata (m_hrdata),
        .m_hready (m_hready),
        .m_hresp  (m_hresp),
        .s_haddr  (s_haddr),
        .s_hwrite (s_hwrite),
        .s_hsize  (s_hsize),
        .s_htrans (s_htrans),
        .s_hwdata (s_hwdata),
        .s_hrdata (s_hrdata),
        .s_hready (s_hready),
        .s_hresp  (s_hresp)
    );

    // ---------------- SRAM slave model ----------------
    logic        stall;
    logic        err_force;
    logic        pre_we;
    logic [7:0]  pre_idx;
    logic [31:0] pre_data;
    logic [31:0] mem [0:255];
    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;

    assign s_hready = ~stall;
    assign s_hresp  = err_force;
    assign s_hrdata = (dp_valid && !dp_write) ? mem[dp_addr[9:2]] : 32'h0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else if (s_hready) begin
            dp_valid <= s_htrans[1];
            dp_write <= s_hwrite;
            dp_addr  <= s_haddr;
        end
    end

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_idx] <= pre_data;
        else if (s_hready && dp_valid && dp_write)
            mem[dp_addr[9:2]] <= s_hwdata;
    end

    // ---------------- helpers ----------------
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        m_htrans = 4'b0000;
        m_haddr  = '0;
        m_hwrite = 2'b00;
        m_hsize  = {3'd2, 3'd2};
        m_hwdata = '0;
    endtask

    task automatic preload(input int idx, input logic [31:0] data);
        pre_we   = 1'b1;
        pre_idx  = idx[7:0];
        pre_data = data;
        next_cycle();
        pre_we   = 1'b0;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        stall     = 1'b0;
        err_force = 1'b0;
        idle_all();
        @(posedge clk);
        @(posedge clk);
        #3;
        reset = 1'b0;
        next_cycle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        reset = 1'b1;
        m_htrans = 4'b1010;
        m_haddr  = {32'h200, 32'h100};
        #1;
        n_checks++;
        if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL rst_htrans: got %b expected 00", s_htrans); end
        n_checks++;
        if (m_hready !== 2'b11) begin n_fail++; $display("FAIL rst_hready: got %b expected 11", m_hready); end
        n_checks++;
        if (m_hresp !== 2'b00) begin n_fail++; $display("FAIL rst_hresp: got %b expected 00", m_hresp); end
        n_checks++;
        if (m_hrdata !== 64'h0) begin n_fail++; $display("FAIL rst_hrdata: got %h expected 0", m_hrdata); end
        idle_all();
    endtask

    task automatic test_uncontended;
        logic [31:0] exp_rd [3];
        exp_rd[0] = 32'h1111_1111;
        exp_rd[1] = 32'h2222_2222;
        exp_rd[2] = 32'h3333_3333;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                m_htrans[1:0] = 2'b10;
                m_haddr[31:0] = 32'(4 * k);
            end else begin
                m_htrans[1:0] = 2'b00;
            end
            @(negedge clk);
            if (k < 3) begin
                n_checks++;
                if (s_haddr !== 32'(4 * k)) begin n_fail++; $display("FAIL unc_addr%0d: got %h expected %h", k, s_haddr, 32'(4 * k)); end
            end
            n_checks++;
            if (m_hready[0] !== 1'b1) begin n_fail++; $display("FAIL unc_ready%0d: got %b expected 1", k, m_hready[0]); end
            if (k > 0) begin
                n_checks++;
                if (m_hrdata[31:0] !== exp_rd[k-1]) begin n_fail++; $display("FAIL unc_data%0d: got %h expected %h", k, m_hrdata[31:0], exp_rd[k-1]); end
            end
            next_cycle();
        end
        idle_all();
    endtask

    task automatic test_first_tie;
        int cnt0;
        int cnt1;
        cnt0 = 0;
        cnt1 = 0;
        do_reset();
        m_htrans = 4'b1010;
        m_haddr  = {32'h200, 32'h100};
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) begin
                n_checks++;
                if (s_haddr !== 32'h100) begin n_fail++; $display("FAIL tie_addr0: got %h expected 00000100", s_haddr); end
                n_checks++;
                if (m_hready !== 2'b01) begin n_fail++; $display("FAIL tie_ready0: got %b expected 01", m_hready); end
            end
            if (i == 1) begin
                n_checks++;
                if (s_haddr !== 32'h200) begin n_fail++; $display("FAIL tie_addr1: got %h expected 00000200", s_haddr); end
                n_checks++;
                if (m_hready !== 2'b10) begin n_fail++; $display("FAIL tie_ready1: got %b expected 10", m_hready); end
            end
            if (m_hready[0] === 1'b1) cnt0++;
            if (m_hready[1] === 1'b1) cnt1++;
            next_cycle();
        end
        idle_all();
        next_cycle();
        next_cycle();
        n_checks++;
        if (cnt0 != 10) begin n_fail++; $display("FAIL tie_count_m0: got %0d expected 10", cnt0); end
        n_checks++;
        if (cnt1 != 10) begin n_fail++; $display("FAIL tie_count_m1: got %0d expected 10", cnt1); end
    endtask

    // Puts m1's read of 0x40 in its data phase while m0 wins m1's next address.
    task automatic setup_latch;
        do_reset();
        m_htrans = 4'b1000;
        m_haddr  = {32'h40, 32'h0};
        next_cycle();
        m_htrans = 4'b1010;
        m_haddr  = {32'h44, 32'h48};
        @(negedge clk);
        n_checks++;
        if (m_hready !== 2'b01) begin n_fail++; $display("FAIL lat_ready_lose: got %b expected 01", m_hready); end
        n_checks++;
        if (s_haddr !== 32'h48) begin n_fail++; $display("FAIL lat_addr_m0: got %h expected 00000048", s_haddr); end
        next_cycle();
        m_htrans = 4'b1000;
    endtask

    task automatic test_latched_rdata;
        setup_latch();
        @(negedge clk);
        n_checks++;
        if (m_hready !== 2'b11) begin n_fail++; $display("FAIL lat_ready_deliver: got %b expected 11", m_hready); end
        n_checks++;
        if (m_hrdata[63:32] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lat_data_m1: got %h expected deadbeef", m_hrdata[63:32]); end
        n_checks++;
        if (m_hrdata[31:0] !== 32'h6666_6666) begin n_fail++; $display("FAIL lat_data_m0: got %h expected 66666666", m_hrdata[31:0]); end
        next_cycle();
        idle_all();
        @(negedge clk);
        n_checks++;
        if (m_hrdata[63:32] !== 32'h5555_5555) begin n_fail++; $display("FAIL lat_data_next: got %h expected 55555555", m_hrdata[63:32]); end
        next_cycle();
    endtask

    task automatic test_write_wait;
        do_reset();
        m_htrans = 4'b1000;
        m_hwrite = 2'b10;
        m_haddr  = {32'h80, 32'h0};
        next_cycle();
        m_htrans = 4'b0010;
        m_hwrite = 2'b00;
        m_hwdata = {32'hA5A5_A5A5, 32'h0};
        stall    = 1'b1;
        for (int w = 0; w < 2; w++) begin
            @(negedge clk);
            n_checks++;
            if (m_hready !== 2'b00) begin n_fail++; $display("FAIL ww_ready%0d: got %b expected 00", w, m_hready); end
            n_checks++;
            if (s_hwdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ww_wdata%0d: got %h expected a5a5a5a5", w, s_hwdata); end
            n_checks++;
            if (s_haddr !== 32'h0 || s_htrans !== 2'b10) begin n_fail++; $display("FAIL ww_addr%0d: got %h/%b expected 00000000/10", w, s_haddr, s_htrans); end
            next_cycle();
        end
        stall = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_hready !== 2'b11) begin n_fail++; $display("FAIL ww_ready_go: got %b expected 11", m_hready); end
        n_checks++;
        if (s_hwdata !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ww_wdata_go: got %h expected a5a5a5a5", s_hwdata); end
        next_cycle();
        m_htrans = 4'b1000;
        m_haddr  = {32'h80, 32'h0};
        @(negedge clk);
        n_checks++;
        if (m_hrdata[31:0] !== 32'h1111_1111) begin n_fail++; $display("FAIL ww_rd_m0: got %h expected 11111111", m_hrdata[31:0]); end
        next_cycle();
        idle_all();
        @(negedge clk);
        n_checks++;
        if (m_hrdata[63:32] !== 32'hA5A5_A5A5) begin n_fail++; $display("FAIL ww_readback: got %h expected a5a5a5a5", m_hrdata[63:32]); end
        next_cycle();
    endtask

    task automatic test_error;
        do_reset();
        m_htrans = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (s_htrans !== 2'b00 || m_hready !== 2'b11) begin n_fail++; $display("FAIL err_busy: got %b/%b expected 00/11", s_htrans, m_hready); end
        next_cycle();
        m_htrans = 4'b0010;
        m_haddr  = 64'h0;
        next_cycle();
        idle_all();
        err_force = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_hresp !== 2'b01) begin n_fail++; $display("FAIL err_resp: got %b expected 01", m_hresp); end
        n_checks++;
        if (m_hready[0] !== 1'b1) begin n_fail++; $display("FAIL err_ready: got %b expected 1", m_hready[0]); end
        next_cycle();
        err_force = 1'b0;
        @(negedge clk);
        n_checks++;
        if (m_hresp !== 2'b00) begin n_fail++; $display("FAIL err_clear: got %b expected 00", m_hresp); end
        next_cycle();
    endtask

    task automatic test_async_reset;
        setup_latch();
        #1;
        n_checks++;
        if (dut.done !== 2'b10) begin n_fail++; $display("FAIL ar_done_pre: got %b expected 10", dut.done); end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (dut.done !== 2'b00 || dut.dp_own !== 2'b00) begin n_fail++; $display("FAIL ar_state: got done=%b dp_own=%b expected 00/00", dut.done, dut.dp_own); end
        n_checks++;
        if (s_htrans !== 2'b00) begin n_fail++; $display("FAIL ar_htrans: got %b expected 00", s_htrans); end
        n_checks++;
        if (m_hready !== 2'b11 || m_hrdata !== 64'h0 || m_hresp !== 2'b00) begin n_fail++; $display("FAIL ar_outputs: got %b/%h/%b expected 11/0/00", m_hready, m_hrdata, m_hresp); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        idle_all();
        next_cycle();
        m_htrans = 4'b1010;
        m_haddr  = {32'h200, 32'h100};
        @(negedge clk);
        n_checks++;
        if (s_haddr !== 32'h100 || m_hready !== 2'b01) begin n_fail++; $display("FAIL ar_tie0: got %h/%b expected 00000100/01", s_haddr, m_hready); end
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (s_haddr !== 32'h200) begin n_fail++; $display("FAIL ar_tie1: got %h expected 00000200", s_haddr); end
        next_cycle();
        idle_all();
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        err_force = 1'b0;
        pre_we    = 1'b0;
        pre_idx   = '0;
        pre_data  = '0;
        idle_all();
        for (int i = 0; i < 256; i++) preload(i, {24'hC0FFEE, 8'(i)});
        preload(0,  32'h1111_1111);
        preload(1,  32'h2222_2222);
        preload(2,  32'h3333_3333);
        preload(16, 32'hDEAD_BEEF);
        preload(17, 32'h5555_5555);
        preload(18, 32'h6666_6666);

        test_reset();
        test_uncontended();
        test_first_tie();
        test_latched_rdata();
        test_write_wait();
        test_error();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_hasti_arbiter.md
# vscale_hasti_arbiter

Two-master, one-slave HASTI (AHB-Lite) arbiter. It lets the core's instruction port (master 0) and data port (master 1) share a single `vscale_hasti_sram` instance. Arbitration is round-robin with zero added latency when uncontended. A master that loses arbitration while its previous data phase completes gets that data phase's response latched and delivered later. It sits between `vscale_hasti_wrapper` and the shared SRAM in a unified-memory top level. The top level ties the SRAM's hburst to SINGLE and its hmastlock and hprot inputs to 0.

## Interface
Parameters:
- None.

Ports (per-master buses are packed `{m1, m0}`):
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  reset, asynchronous, active-high.
- `m_haddr`  in  64  master address phase addresses.
- `m_hwrite`  in  2  master write flags.
- `m_hsize`  in  6  master transfer sizes, 3 bits each.
- `m_htrans`  in  4  master transfer types, 2 bits each; bit 1 set = request.
- `m_hwdata`  in  64  master write data, data phase.
- `m_hrdata`  out  64  read data returned to each master.
- `m_hready`  out  2  per-master HREADY.
- `m_hresp`  out  2  per-master HRESP; 1 = ERROR.
- `s_haddr`  out  32  slave address.
- `s_hwrite`  out  1  slave write flag.
- `s_hsize`  out  3  slave size.
- `s_htrans`  out  2  slave transfer type.
- `s_hwdata`  out  32  slave write data.
- `s_hrdata`  in  32  slave read data.
- `s_hready`  in  1  slave HREADY.
- `s_hresp`  in  1  slave HRESP.

## Operation
State:
- `last_grant` (1 bit). Reset value 1, so master 0 wins the first tie.
- `dp_own[1:0]`, one-hot or zero: the master owning the slave data phase. Reset value 0.
- `done[1:0]`: latched, undelivered completion per master. Reset value 0.
- `rdata_q[i]` (32 bits) and `resp_q[i]` (1 bit) per master. Reset value 0.

Arbitration:
- `req_i = m_htrans[i][1]`. IDLE and BUSY are not requests.
- Grant is a function of `req` and `last_grant` only. It never depends on `s_hready`.
  - One requester: that requester is granted.
  - Both requesting: the master that is not `last_grant` is granted.
  - No requester: no grant.
- `accept_i = grant_i & s_hready`. On accept, `last_grant <= i`.

Slave muxing:
- `s_haddr`, `s_hwrite`, `s_hsize`, `s_htrans` come from the granted master.
- With no grant: `s_htrans` = IDLE (2'b00); the other fields come from master 0.
- `s_hwdata` comes from the `dp_own` master, or from master 0 when `dp_own` is 0.

Data-phase ownership:
- When `s_hready=1`: `dp_own <= accept` (one-hot or 0).
- Otherwise `dp_own` holds.

Per-master ready:
- `data_ok_i = done_i | ~dp_own_i | s_hready`.
- `addr_ok_i = ~req_i | accept_i`.
- `m_hready[i] = data_ok_i & addr_ok_i`.

Latching a completed but undelivered data phase:
- Condition: `dp_own_i & s_hready & ~m_hready[i]`.
- Action: `done_i <= 1`, `rdata_q[i] <= s_hrdata`, `resp_q[i] <= s_hresp`.
- `done_i` clears on any cycle with `m_hready[i]=1`.

Response muxing:
- If `done_i`: `m_hrdata[i] = rdata_q[i]`, `m_hresp[i] = resp_q[i]`.
- Else if `dp_own_i`: pass through `s_hrdata` and `s_hresp`.
- Else: `m_hrdata[i] = 0`, `m_hresp[i] = 0`.
- A latched ERROR is delivered in a single cycle with hresp=1 and hready=1. vscale masters sample hresp only with hready.

Reset behaviour:
- While `reset=1`, grant is forced to none. Outputs are `s_htrans`=IDLE, `m_hready`=2'b11, `m_hresp`=0, `m_hrdata`=0.
- Assertion mid-transfer discards `done` and `dp_own` immediately, without waiting for a clock edge.

## Timing
- Uncontended path is fully combinational:
  - `m_htrans` to `s_htrans`.
  - `s_hready` to `m_hready`.
  - `s_hrdata` to `m_hrdata`.
- No path from `s_hready` to any `s_h*` address-phase output.
- Under contention, the loser's address phase is delayed exactly one accepted slave cycle per conflict.
- Continuous two-master contention alternates grants every accepted cycle. No starvation.
- While `s_hready=0`:
  - no state changes except latching is suppressed;
  - `s_h*` address outputs stay stable as long as the masters hold their inputs, per AHB.

## Test plan
1. **Uncontended reads.** Master 0 reads 0x0, 0x4, 0x8 back-to-back; master 1 idle; SRAM preloaded. Required: `s_haddr` mirrors `m_haddr[31:0]` in the same cycle, `m_hready[0]=1` every cycle, and the data words are returned one cycle after each address.
2. **First tie after reset.** Both masters issue NONSEQ in the first cycle after reset (m0 at 0x100, m1 at 0x200). Required: `s_haddr`=0x100 and `m_hready`=2'b01; next cycle `s_haddr`=0x200. Over 20 cycles of continuous contention, each master gets 10 accepts.
3. **Latched read data.** Master 1 has a read of 0x40 (data 0xDEADBEEF) in its data phase and loses its next address to master 0. Required: `m_hrdata[63:32]`=0xDEADBEEF with `m_hready[1]=1` in the cycle master 1's next address is accepted, although `s_hrdata` has changed.
4. **Write under wait states.** Master 1 writes 0xA5A5A5A5 to 0x80 while the slave drives `s_hready=0` for 2 cycles. Required: `s_hwdata`=0xA5A5A5A5 throughout; `m_hready`=2'b00 for both wait cycles if both have outstanding phases; the SRAM contains the value afterwards.
5. **Error pass-through.** Slave returns ERROR to master 0's read. Required: `m_hresp[0]=1` in the completing cycle; `m_hresp[1]=0`.
6. **Asynchronous reset mid-transfer.** Assert `reset` between clock edges while `done[1]=1`. Required: `done`=0, `dp_own`=0, `s_htrans`=IDLE and `m_hready`=2'b11 immediately. After release, the first tie goes to master 0.
